// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_INST_WIDTH = 32;
    localparam logic [31:0] DEF_RESET_PC   = 32'hBFC0_0000;
    localparam int unsigned PC_INC         = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_inst_buffer.sv
// Holds the instruction (plus its address-error flag) fetched while the pipeline was stalled.
module fetch_inst_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned INST_WIDTH = DEF_INST_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [INST_WIDTH:0]   d,
    output logic [INST_WIDTH:0]   q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, ROM request handshake, stall hold buffer, branch/flush redirect.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned           INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_in,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ready,
    input  logic [INST_WIDTH-1:0] rom_rdata,
    output logic                  stall_request,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  inst_valid,
    output logic                  adel_out
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  misaligned;
    logic                  fetch_done;
    logic                  advance;
    logic                  capture;
    logic [INST_WIDTH:0]   buf_d;
    logic [INST_WIDTH:0]   buf_q;

    assign misaligned = |pc[1:0];
    // A misaligned PC completes immediately without touching the ROM.
    assign fetch_done = misaligned || rom_ready;
    assign advance    = !stall_in && (((state == REQ) && fetch_done) || (state == HOLD));
    assign capture    = !flush && (state == REQ) && fetch_done && stall_in;
    assign pc_next    = branch_taken ? branch_target : pc + ADDR_WIDTH'(PC_INC);
    assign buf_d      = {misaligned, misaligned ? {INST_WIDTH{1'b0}} : rom_rdata};

    fetch_inst_buffer #(
        .INST_WIDTH (INST_WIDTH)
    ) u_inst_buffer (
        .clk  (clk),
        .rst  (rst),
        .load (capture),
        .d    (buf_d),
        .q    (buf_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else if (flush) begin
            state <= REQ;
            pc    <= flush_pc;
        end else begin
            case (state)
                BOOT: state <= REQ;
                REQ: begin
                    if (advance) begin
                        pc <= pc_next;
                    end else if (fetch_done) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (advance) begin
                        pc    <= pc_next;
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_comb begin
        rom_en        = (state == REQ) && !misaligned;
        rom_addr      = {pc[ADDR_WIDTH-1:2], 2'b00};
        pc_out        = pc;
        stall_request = 1'b0;
        inst_valid    = 1'b0;
        inst_out      = '0;
        adel_out      = 1'b0;
        case (state)
            // The reset state is BOOT, so mask the BOOT stall while rst is held.
            BOOT: stall_request = !rst;
            REQ: begin
                if (misaligned) begin
                    inst_valid = 1'b1;
                    adel_out   = 1'b1;
                end else begin
                    stall_request = !rom_ready;
                    inst_valid    = rom_ready;
                    if (rom_ready) begin
                        inst_out = rom_rdata;
                    end
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                inst_out   = buf_q[INST_WIDTH-1:0];
                adel_out   = buf_q[INST_WIDTH];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs change on the falling edge, outputs checked 1ns later.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready;
    logic [31:0] rom_rdata;
    logic        stall_request;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        adel_out;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .RESET_PC   (32'hBFC0_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rom_en        (rom_en),
        .rom_addr      (rom_addr),
        .rom_ready     (rom_ready),
        .rom_rdata     (rom_rdata),
        .stall_request (stall_request),
        .pc_out        (pc_out),
        .inst_out      (inst_out),
        .inst_valid    (inst_valid),
        .adel_out      (adel_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0; flush_pc = '0;
        branch_taken = 1'b0; branch_target = '0; rom_ready = 1'b0; rom_rdata = '0;
        #2 rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en got=%0b exp=0", rom_en); end
        checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", stall_request); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL rst_inst got=%h exp=00000000", inst_out); end
        checks++; if (adel_out !== 1'b0) begin errors++; $display("FAIL rst_adel got=%0b exp=0", adel_out); end
        checks++; if (pc_out !== 32'hBFC0_0000) begin errors++; $display("FAIL rst_pc got=%h exp=bfc00000", pc_out); end
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL boot_stall got=%0b exp=1", stall_request); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL boot_rom_en got=%0b exp=0", rom_en); end
    endtask

    task automatic test_first_fetch();
        @(negedge clk); #1;
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL ff_rom_en got=%0b exp=1", rom_en); end
        checks++; if (rom_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ff_addr0 got=%h exp=bfc00000", rom_addr); end
        checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL ff_stall0 got=%0b exp=1", stall_request); end
        @(negedge clk); #1;
        checks++; if (rom_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ff_addr1 got=%h exp=bfc00000", rom_addr); end
        checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL ff_stall1 got=%0b exp=1", stall_request); end
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'h2408_0001; #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ff_valid got=%0b exp=1", inst_valid); end
        checks++; if (inst_out !== 32'h2408_0001) begin errors++; $display("FAIL ff_inst got=%h exp=24080001", inst_out); end
        checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL ff_stall2 got=%0b exp=0", stall_request); end
        @(negedge clk); rom_ready = 1'b0; #1;
        checks++; if (rom_addr !== 32'hBFC0_0004) begin errors++; $display("FAIL ff_next_addr got=%h exp=bfc00004", rom_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ff_wait_valid got=%0b exp=0", inst_valid); end
    endtask

    task automatic test_stall_hold();
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'h8C09_0000; stall_in = 1'b1; #1;
        checks++; if (inst_out !== 32'h8C09_0000) begin errors++; $display("FAIL sh_inst_req got=%h exp=8c090000", inst_out); end
        @(negedge clk); rom_ready = 1'b0; rom_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL sh_rom_en got=%0b exp=0", rom_en); end
        checks++; if (inst_out !== 32'h8C09_0000) begin errors++; $display("FAIL sh_inst_hold got=%h exp=8c090000", inst_out); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL sh_valid got=%0b exp=1", inst_valid); end
        checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL sh_stall got=%0b exp=0", stall_request); end
        checks++; if (pc_out !== 32'hBFC0_0004) begin errors++; $display("FAIL sh_pc got=%h exp=bfc00004", pc_out); end
        @(negedge clk); stall_in = 1'b0; #1;
        checks++; if (inst_out !== 32'h8C09_0000) begin errors++; $display("FAIL sh_inst_release got=%h exp=8c090000", inst_out); end
        @(negedge clk); #1;
        checks++; if (rom_addr !== 32'hBFC0_0008) begin errors++; $display("FAIL sh_next_addr got=%h exp=bfc00008", rom_addr); end
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL sh_next_en got=%0b exp=1", rom_en); end
    endtask

    task automatic test_branch();
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'h0000_0000;
        @(negedge clk); #1;
        checks++; if (rom_addr !== 32'hBFC0_000C) begin errors++; $display("FAIL br_addr_c got=%h exp=bfc0000c", rom_addr); end
        @(negedge clk); rom_rdata = 32'h1000_003B; #1;
        checks++; if (rom_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL br_addr_10 got=%h exp=bfc00010", rom_addr); end
        @(negedge clk); rom_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'hBFC0_0100; #1;
        checks++; if (rom_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL br_delay_addr got=%h exp=bfc00014", rom_addr); end
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'h0000_0000; #1;
        checks++; if (rom_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL br_delay_fetch got=%h exp=bfc00014", rom_addr); end
        @(negedge clk); rom_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; #1;
        checks++; if (rom_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL br_target got=%h exp=bfc00100", rom_addr); end
    endtask

    task automatic test_flush();
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'h1234_5678; stall_in = 1'b1;
        flush = 1'b1; flush_pc = 32'hBFC0_0380; #1;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fl_valid got=%0b exp=1", inst_valid); end
        @(negedge clk); flush = 1'b0; stall_in = 1'b0; rom_ready = 1'b0; #1;
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL fl_rom_en got=%0b exp=1", rom_en); end
        checks++; if (rom_addr !== 32'hBFC0_0380) begin errors++; $display("FAIL fl_addr got=%h exp=bfc00380", rom_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got=%0b exp=0", inst_valid); end
    endtask

    task automatic test_misaligned();
        @(negedge clk); flush = 1'b1; flush_pc = 32'h8000_0002;
        @(negedge clk); flush = 1'b0; rom_rdata = 32'hFFFF_FFFF; stall_in = 1'b1; #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL ma_rom_en got=%0b exp=0", rom_en); end
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ma_valid got=%0b exp=1", inst_valid); end
        checks++; if (adel_out !== 1'b1) begin errors++; $display("FAIL ma_adel got=%0b exp=1", adel_out); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL ma_inst got=%h exp=00000000", inst_out); end
        checks++; if (pc_out !== 32'h8000_0002) begin errors++; $display("FAIL ma_pc got=%h exp=80000002", pc_out); end
        checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL ma_stall got=%0b exp=0", stall_request); end
        @(negedge clk); stall_in = 1'b0; #1;
        checks++; if (adel_out !== 1'b1) begin errors++; $display("FAIL ma_adel_held got=%0b exp=1", adel_out); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h8000_0006) begin errors++; $display("FAIL ma_pc_adv got=%h exp=80000006", pc_out); end
    endtask

    task automatic test_wrap();
        @(negedge clk); flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        @(negedge clk); flush = 1'b0; rom_ready = 1'b1; rom_rdata = 32'h0000_0000; #1;
        checks++; if (rom_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got=%h exp=fffffffc", rom_addr); end
        checks++; if (adel_out !== 1'b0) begin errors++; $display("FAIL wr_adel0 got=%0b exp=0", adel_out); end
        @(negedge clk); rom_ready = 1'b0; #1;
        checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL wr_wrapped got=%h exp=00000000", rom_addr); end
        checks++; if (adel_out !== 1'b0) begin errors++; $display("FAIL wr_adel1 got=%0b exp=0", adel_out); end
    endtask

    task automatic test_reset_mid_request();
        @(negedge clk); rom_ready = 1'b1; rom_rdata = 32'hAAAA_5555; rst = 1'b1; #1;
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL mr_rom_en got=%0b exp=0", rom_en); end
        checks++; if (stall_request !== 1'b0) begin errors++; $display("FAIL mr_stall got=%0b exp=0", stall_request); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL mr_valid got=%0b exp=0", inst_valid); end
        checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL mr_inst got=%h exp=00000000", inst_out); end
        checks++; if (pc_out !== 32'hBFC0_0000) begin errors++; $display("FAIL mr_pc got=%h exp=bfc00000", pc_out); end
        @(negedge clk); rst = 1'b0; rom_ready = 1'b0; #1;
        checks++; if (stall_request !== 1'b1) begin errors++; $display("FAIL mr_boot_stall got=%0b exp=1", stall_request); end
        checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL mr_boot_en got=%0b exp=0", rom_en); end
        @(negedge clk); #1;
        checks++; if (rom_en !== 1'b1) begin errors++; $display("FAIL mr_req_en got=%0b exp=1", rom_en); end
        checks++; if (rom_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL mr_req_addr got=%h exp=bfc00000", rom_addr); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_branch();
        test_flush();
        test_misaligned();
        test_wrap();
        test_reset_mid_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage. Holds the PC and runs a ready-based request handshake with the instruction ROM or cache port.
- Presents one instruction per advance to the IF/ID pipeline register, and raises a stall request while an instruction is outstanding.
- Handles branch redirect (MIPS delay-slot semantics), flush redirect and misaligned-PC address errors.

Parameters:
- ADDR_WIDTH, 32: PC / ROM address width.
- INST_WIDTH, 32: instruction width.
- RESET_PC, 32'hBFC00000: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_in  in  1  stall for the IF stage from the pipeline controller; 1 = do not advance.
- flush  in  1  exception/eret redirect.
- flush_pc  in  ADDR_WIDTH  redirect target, valid when flush=1.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  ADDR_WIDTH  branch destination.
- rom_en  out  1  ROM request valid.
- rom_addr  out  ADDR_WIDTH  ROM request address (word-aligned).
- rom_ready  in  1  ROM has accepted the request; rom_rdata is valid this cycle.
- rom_rdata  in  INST_WIDTH  instruction data.
- stall_request  out  1  IF cannot produce an instruction this cycle.
- pc_out  out  ADDR_WIDTH  PC of the presented instruction.
- inst_out  out  INST_WIDTH  presented instruction.
- inst_valid  out  1  pc_out and inst_out are meaningful.
- adel_out  out  1  fetch address error (pc[1:0]!=0).

Behaviour:
- Reset (asynchronous, active-high):
  - pc=RESET_PC, state=BOOT, inst_buf=0.
  - Outputs during reset: rom_en=0, stall_request=0, inst_valid=0, inst_out=0, adel_out=0, pc_out=RESET_PC.
  - Reset asserted mid-request drops the request immediately; a rom_ready in that cycle is ignored.
- States: BOOT, REQ, HOLD.
- BOOT:
  - Outputs idle; stall_request=1.
  - Next cycle goes to REQ unconditionally (one idle cycle after reset release).
- REQ, aligned pc:
  - rom_en=1, rom_addr=pc; the address is held stable until rom_ready.
  - stall_request = !rom_ready.
  - When rom_ready=1: inst_out=rom_rdata (combinational pass-through), inst_valid=1.
- REQ, misaligned pc:
  - rom_en=0, inst_valid=1, adel_out=1, inst_out=0, stall_request=0.
  - No ROM access is made.
- Advance event: (REQ && (rom_ready || misaligned) && !stall_in) or (HOLD && !stall_in).
  - pc <= branch_taken ? branch_target : pc+4 (modulo 2^ADDR_WIDTH).
  - Next state is REQ.
  - branch_taken/branch_target are sampled only at the advance. ID holds them stable while the delay-slot fetch completes, so the delay slot is always fetched before the redirect.
- Capture without advance: REQ && rom_ready && stall_in.
  - inst_buf <= rom_rdata; adel state is captured too.
  - Next state is HOLD.
- HOLD:
  - rom_en=0, inst_valid=1, inst_out=inst_buf, pc_out=pc, stall_request=0.
  - Stays in HOLD until !stall_in.
- Flush (highest priority, any state except reset):
  - pc <= flush_pc, state <= REQ.
  - Any rom_ready/rom_rdata in the same cycle is discarded.
  - A pending branch_taken is ignored.
  - inst_valid is still shown combinationally that cycle; downstream flush logic kills it.
- Simultaneous flush and stall_in: flush wins.
- PC wrap: pc+4 wraps at 2^ADDR_WIDTH without any error.

Decomposition:
- Shared package/header:
  - state encoding (BOOT=2'd0, REQ=2'd1, HOLD=2'd2);
  - PC_INC=4;
  - RESET_PC default;
  - ADDR_WIDTH and INST_WIDTH defaults.
- Sub-module fetch_inst_buffer:
  - INST_WIDTH+1 register (inst + adel) with load enable;
  - asynchronous reset to 0.
- Next-PC mux and FSM stay in fetch_stage.

Test Plan:
1. Reset release, rom_ready after 2 cycles: one BOOT cycle, then rom_addr=BFC00000 held for 2 cycles with stall_request=1. On rom_ready with rdata=0x24080001: inst_valid=1, next rom_addr=BFC00004.
2. stall_in=1 on the rom_ready cycle (rdata=0x8C090000): HOLD entered, rom_en=0, inst_out stays 0x8C090000. When stall_in drops: advance, then rom_addr=pc+4.
3. Branch at pc=BFC00010, branch_taken=1 held, branch_target=BFC00100: delay slot BFC00014 is fetched first, then rom_addr=BFC00100.
4. flush=1, flush_pc=0xBFC00380 in the same cycle as rom_ready: that data is dropped; next cycle rom_addr=BFC00380 in REQ.
5. flush_pc=0x80000002: rom_en=0, inst_valid=1, adel_out=1, inst_out=0, pc_out=0x80000002, with no ROM access.
6. rst asserted mid-request (REQ, rom_ready=0): outputs drop to reset values asynchronously; after release the FSM restarts in BOOT with pc=BFC00000. Also cover pc=FFFFFFFC advancing: wraps to 00000000.
